// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage IF/ID/EX/LS/WB pipeline: load-use,
// jump redirect, fetch bubbles, LS memory waits with timeout, ebreak drain/halt.
module pipe_hazard_ctrl #(
    parameter int unsigned LS_TIMEOUT = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_idx_id,
    input  logic [4:0]       rs2_idx_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             halt_req_id,
    input  logic [4:0]       rd_idx_ex,
    input  logic             ld_ex,
    input  logic             wben_ex,
    input  logic             is_jump_ex,
    input  logic             if_valid,
    input  logic             ls_req,
    input  logic             ls_ready,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_ls,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             bubble_wb,
    output logic             halted_o,
    output logic             ls_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned TO_W = 16;
    localparam int unsigned DR_W = 2;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LS_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    logic [1:0]      state, state_nx;
    logic [1:0]      ret_state, ret_nx;
    logic [1:0]      mode;
    logic [DR_W-1:0] drain_cnt, drain_nx;
    logic [TO_W-1:0] to_cnt, to_nx;
    logic            lu_seen, lu_nx;
    logic            halt_set, err_set, resolve;
    logic            mem_wait, load_use;
    logic            pc_h, id_h, ex_h, ls_h, id_f, ex_f, wb_b;

    assign mem_wait = ls_req & ~ls_ready;
    assign load_use = ld_ex & wben_ex & (rd_idx_ex != 5'd0) &
                      ((rs1_used_id & (rs1_idx_id == rd_idx_ex)) |
                       (rs2_used_id & (rs2_idx_id == rd_idx_ex)));

    // Next state and control decode; LS release reuses the RUN/DRAIN resolver
    // of the recorded return state so a held jump or hazard is not lost.
    always_comb begin
        state_nx = state;
        ret_nx   = ret_state;
        drain_nx = drain_cnt;
        to_nx    = '0;
        lu_nx    = 1'b0;
        halt_set = 1'b0;
        err_set  = 1'b0;
        resolve  = 1'b0;
        mode     = state;
        pc_h     = 1'b0;
        id_h     = 1'b0;
        ex_h     = 1'b0;
        ls_h     = 1'b0;
        id_f     = 1'b0;
        ex_f     = 1'b0;
        wb_b     = 1'b0;

        case (state)
            ST_RUN, ST_DRAIN: begin
                resolve = 1'b1;
            end
            ST_LS_WAIT: begin
                err_set = (to_cnt == TO_W'(LS_TIMEOUT));
                if (ls_ready) begin
                    resolve = 1'b1;
                    mode    = ret_state;
                end else begin
                    to_nx = (to_cnt != '1) ? to_cnt + TO_W'(1) : to_cnt;
                    pc_h  = 1'b1;
                    id_h  = 1'b1;
                    ex_h  = 1'b1;
                    ls_h  = 1'b1;
                    wb_b  = 1'b1;
                end
            end
            ST_HALT: begin
                pc_h = 1'b1;
                id_h = 1'b1;
                ex_h = 1'b1;
                ls_h = 1'b1;
                wb_b = 1'b1;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        if (resolve) begin
            if (mem_wait) begin
                pc_h     = 1'b1;
                id_h     = 1'b1;
                ex_h     = 1'b1;
                ls_h     = 1'b1;
                wb_b     = 1'b1;
                ret_nx   = mode;
                state_nx = ST_LS_WAIT;
            end else if (is_jump_ex) begin
                id_f     = 1'b1;
                ex_f     = 1'b1;
                state_nx = ST_RUN;
            end else if ((mode == ST_RUN) && load_use && !lu_seen) begin
                pc_h     = 1'b1;
                id_h     = 1'b1;
                ex_f     = 1'b1;
                lu_nx    = 1'b1;
                state_nx = ST_RUN;
            end else if ((mode == ST_RUN) && halt_req_id) begin
                pc_h     = 1'b1;
                id_f     = 1'b1;
                drain_nx = DR_W'(2);
                state_nx = ST_DRAIN;
            end else if (mode == ST_DRAIN) begin
                pc_h = 1'b1;
                id_f = 1'b1;
                if (drain_cnt == '0) begin
                    halt_set = 1'b1;
                    state_nx = ST_HALT;
                end else begin
                    drain_nx = drain_cnt - DR_W'(1);
                    state_nx = ST_DRAIN;
                end
            end else begin
                pc_h     = ~if_valid;
                id_f     = ~if_valid;
                state_nx = ST_RUN;
            end
        end
    end

    // Controls are forced low while reset is asserted.
    assign stall_pc  = rst_n & pc_h;
    assign stall_id  = rst_n & id_h;
    assign stall_ex  = rst_n & ex_h;
    assign stall_ls  = rst_n & ls_h;
    assign flush_id  = rst_n & id_f;
    assign flush_ex  = rst_n & ex_f;
    assign bubble_wb = rst_n & wb_b;

    // State, counters and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            ret_state   <= ST_RUN;
            drain_cnt   <= '0;
            to_cnt      <= '0;
            lu_seen     <= 1'b0;
            halted_o    <= 1'b0;
            ls_err_o    <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            drain_cnt <= drain_nx;
            to_cnt    <= to_nx;
            lu_seen   <= lu_nx;
            if (halt_set) begin
                halted_o <= 1'b1;
            end
            if (err_set) begin
                ls_err_o <= 1'b1;
            end
            if (pc_h && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, with a 3-bit counter copy
// to observe stall_cnt_o saturation.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_idx_id, rs2_idx_id, rd_idx_ex;
    logic        rs1_used_id, rs2_used_id, halt_req_id;
    logic        ld_ex, wben_ex, is_jump_ex, if_valid, ls_req, ls_ready;
    logic        stall_pc, stall_id, stall_ex, stall_ls, flush_id, flush_ex, bubble_wb;
    logic        halted_o, ls_err_o;
    logic [31:0] stall_cnt_o;
    logic        s_pc, s_id, s_ex, s_ls, s_fid, s_fex, s_wb, s_halted, s_err;
    logic [2:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LS_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_idx_id(rs1_idx_id), .rs2_idx_id(rs2_idx_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .halt_req_id(halt_req_id), .rd_idx_ex(rd_idx_ex),
        .ld_ex(ld_ex), .wben_ex(wben_ex), .is_jump_ex(is_jump_ex),
        .if_valid(if_valid), .ls_req(ls_req), .ls_ready(ls_ready),
        .stall_pc(stall_pc), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_ls(stall_ls), .flush_id(flush_id), .flush_ex(flush_ex),
        .bubble_wb(bubble_wb), .halted_o(halted_o), .ls_err_o(ls_err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    pipe_hazard_ctrl #(.LS_TIMEOUT(8), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .rs1_idx_id(rs1_idx_id), .rs2_idx_id(rs2_idx_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .halt_req_id(halt_req_id), .rd_idx_ex(rd_idx_ex),
        .ld_ex(ld_ex), .wben_ex(wben_ex), .is_jump_ex(is_jump_ex),
        .if_valid(if_valid), .ls_req(ls_req), .ls_ready(ls_ready),
        .stall_pc(s_pc), .stall_id(s_id), .stall_ex(s_ex),
        .stall_ls(s_ls), .flush_id(s_fid), .flush_ex(s_fex),
        .bubble_wb(s_wb), .halted_o(s_halted), .ls_err_o(s_err),
        .stall_cnt_o(s_cnt)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rs2;
        logic        rs2u;
        logic [4:0]  rd;
        logic        ld, wb, jmp, hreq, ifv, lreq, lrdy;
        logic [6:0]  ctrl;
        logic        halted;
        logic [31:0] cnt;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [4:0] rs1, logic rs1u, logic [4:0] rs2, logic rs2u,
                               logic [4:0] rd, logic ld, logic wb, logic jmp, logic hreq,
                               logic ifv, logic lreq, logic lrdy, logic [6:0] ctrl,
                               logic halted, int cnt, logic err);
        vec_t t;
        t.rs1 = rs1; t.rs1u = rs1u; t.rs2 = rs2; t.rs2u = rs2u; t.rd = rd;
        t.ld = ld; t.wb = wb; t.jmp = jmp; t.hreq = hreq; t.ifv = ifv;
        t.lreq = lreq; t.lrdy = lrdy; t.ctrl = ctrl; t.halted = halted;
        t.cnt = 32'(cnt); t.err = err;
        return t;
    endfunction

    function automatic vec_t idle(int cnt);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000, 0, cnt, 0);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        rs1_idx_id = t.rs1; rs1_used_id = t.rs1u; rs2_idx_id = t.rs2; rs2_used_id = t.rs2u;
        rd_idx_ex = t.rd; ld_ex = t.ld; wben_ex = t.wb; is_jump_ex = t.jmp;
        halt_req_id = t.hreq; if_valid = t.ifv; ls_req = t.lreq; ls_ready = t.lrdy;
    endtask

    task automatic apply(string tag, vec_t t);
        logic [6:0]  ctrl_act, s_ctrl_act;
        logic [31:0] sat;
        @(negedge clk);
        drive(t);
        #1;
        ctrl_act   = {stall_pc, stall_id, stall_ex, stall_ls, flush_id, flush_ex, bubble_wb};
        s_ctrl_act = {s_pc, s_id, s_ex, s_ls, s_fid, s_fex, s_wb};
        sat        = (t.cnt > 32'd7) ? 32'd7 : t.cnt;
        chk({tag, " ctrl"}, 32'(ctrl_act), 32'(t.ctrl));
        chk({tag, " halted"}, 32'(halted_o), 32'(t.halted));
        chk({tag, " ls_err"}, 32'(ls_err_o), 32'(t.err));
        chk({tag, " stall_cnt"}, stall_cnt_o, t.cnt);
        chk({tag, " sat_cnt"}, 32'(s_cnt), sat);
        chk({tag, " sat_copy"}, 32'({s_ctrl_act, s_halted, s_err}),
            32'({t.ctrl, t.halted, t.err}));
    endtask

    task automatic reset_check(string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({tag, " ctrl"}, 32'({stall_pc, stall_id, stall_ex, stall_ls, flush_id, flush_ex, bubble_wb}), 32'd0);
        chk({tag, " status"}, 32'({halted_o, ls_err_o}), 32'd0);
        chk({tag, " stall_cnt"}, stall_cnt_o, 32'd0);
        chk({tag, " sat_cnt"}, 32'(s_cnt), 32'd0);
        drive(idle(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with hazard-causing inputs applied: controls must still be low.
        drive(v(5, 1, 0, 0, 5, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        chk("reset ctrl", 32'({stall_pc, stall_id, stall_ex, stall_ls, flush_id, flush_ex, bubble_wb}), 32'd0);
        chk("reset status", 32'({halted_o, ls_err_o}), 32'd0);
        chk("reset stall_cnt", stall_cnt_o, 32'd0);
        drive(idle(0));
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(idle(0));
        tbl.push_back(v(5, 1, 1, 1, 5, 1, 1, 0, 0, 1, 0, 0, 7'b1100010, 0, 0, 0));
        tbl.push_back(v(5, 1, 1, 1, 5, 1, 1, 0, 0, 1, 0, 0, 7'b0000000, 0, 1, 0));
        tbl.push_back(idle(1));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 7'b0000000, 0, 1, 0));
        tbl.push_back(v(5, 0, 7, 1, 5, 1, 1, 0, 0, 1, 0, 0, 7'b0000000, 0, 1, 0));
        tbl.push_back(v(0, 0, 9, 1, 9, 1, 1, 0, 0, 1, 0, 0, 7'b1100010, 0, 1, 0));
        tbl.push_back(idle(2));
        tbl.push_back(v(9, 1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 7'b0000000, 0, 2, 0));
        tbl.push_back(v(9, 1, 0, 0, 9, 0, 1, 0, 0, 1, 0, 0, 7'b0000000, 0, 2, 0));
        tbl.push_back(v(5, 1, 0, 0, 5, 1, 1, 1, 0, 1, 0, 0, 7'b0000110, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1000100, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b0000110, 0, 3, 0));
        tbl.push_back(v(5, 1, 0, 0, 5, 1, 1, 1, 0, 1, 1, 0, 7'b1111001, 0, 3, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 7'b1111001, 0, 4 + i, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 7'b0000110, 0, 7, 0));
        tbl.push_back(idle(7));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 7'b0000110, 0, 7, 0));
        tbl.push_back(idle(7));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b1000100, 0, 7, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1000100, 0, 8 + i, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111001, 1, 11, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 7'b1111001, 1, 12, 0));

        foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

        reset_check("reset_from_halt");

        // Memory never answers for 20 cycles; error latches after the 8th wait count.
        for (int c = 0; c < 20; c++)
            apply($sformatf("timeout%0d", c),
                  v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1111001, 0, c, (c >= 10) ? 1'b1 : 1'b0));
        apply("timeout_release", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b0000000, 0, 20, 1));
        apply("timeout_sticky", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000, 0, 20, 1));

        reset_check("reset_after_timeout");

        // Reset in the middle of an ebreak drain.
        apply("drain_enter", v(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b1000100, 0, 0, 0));
        apply("drain_mid", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1000100, 0, 1, 0));
        reset_check("reset_mid_drain");
        apply("post_reset0", idle(0));
        apply("post_reset1", idle(0));
        apply("post_reset2", idle(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
